imm_pack: RTL
=============

Name: imm_pack

Overview:
- Inverse of the immediate generator: takes a 32-bit signed value and packs it into the 12-bit constant field (rs+rt) or the 6-bit field (rt).
- Reports whether the value fits the selected field; sign-extending the packed field gives the original value back exactly when it fits.
- Sits on the assembler/loader path and test-vector path ahead of instruction memory.
- Two-stage valid/ready pipeline with backpressure, plus a saturating overflow counter.

Parameters:
- CNT_W, 8, width of the overflow event counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a value to pack.
- in_ready  output  1  block can accept this cycle.
- value  input  32  signed value to pack.
- Gen  input  1  1 = 12-bit field (rs+rt), 0 = 6-bit field (rt).
- out_valid  output  1  packed result available.
- out_ready  input  1  downstream accepts result.
- const_out  output  12  packed field.
- fits  output  1  value is representable in the selected field.
- ovf_count  output  CNT_W  number of non-fitting results loaded into stage 2 (saturating).
- cnt_clr  input  1  clear ovf_count.

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset) and wins over all other activity.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, const_out=0, fits=0, ovf_count=0. in_ready is 1 on the first cycle after reset.
- Pipeline advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready.
- Stage 1: on in_valid && in_ready, register value and Gen and set s1_valid. If in_ready=1 and in_valid=0, s1_valid goes to 0.
- Stage 2, on s2_adv:
  - Load the stage-1 result; s2_valid <= s1_valid.
  - Output holds stable while out_valid && !out_ready.
- Latency: 2 cycles from input accept to out_valid with no stall. Throughput is 1 per cycle when out_ready is held at 1.
- Fit rule (performed in stage 1 → stage 2 combinational):
  - Gen=1: fits when value[31:11] are all equal.
  - Gen=0: fits when value[31:5] are all equal.
- Packing:
  - Gen=1: const_out = value[11:0].
  - Gen=0: const_out[5:0] = value[5:0] and const_out[11:6] = 0.
  - A non-fitting value is truncated by the same rule and reported with fits=0.
- ovf_count:
  - Increments by 1 when stage 2 loads a valid entry with fits=0.
  - Holds at 2^CNT_W-1 (no wrap).
  - cnt_clr sets it to 0; cnt_clr wins over a simultaneous increment.
- Reset mid-operation: in-flight entries are discarded, and no output handshake occurs for them.
- Boundary values:
  - Gen=0 range is -32..31.
  - Gen=1 range is -2048..2047.
  - Both range endpoints fit; each endpoint ±1 outside the range does not.

Optional Feature:
- Macro: IMM_PACK_SATURATE_EN.
- Defined: a non-fitting value is clamped to the field extreme of its sign.
  - Gen=1: 0x7FF or 0x800.
  - Gen=0: const_out[5:0] = 0x1F or 0x20, with [11:6] = 0.
  - fits stays 0 and ovf_count still increments.
- Undefined: truncation as in Behaviour.

Decomposition:
- Shared package (shared with imm_gen):
  - IMM_W12=12 and IMM_W6=6.
  - GEN_12=1'b1 and GEN_6=1'b0.
  - Field range constants: IMM12_MAX=2047, IMM12_MIN=-2048, IMM6_MAX=31, IMM6_MIN=-32.
- One sub-module: imm_fit_check. It is combinational and maps value and Gen to fits and a packed field. The saturate option lives inside it.

Test Plan:
- After reset, in_valid=1, value=0x0000001F, Gen=0, out_ready=1 → two cycles later out_valid=1, const_out=0x01F, fits=1, ovf_count=0.
- value=0xFFFFFFE0, Gen=0 → const_out=0x020, fits=1. value=0x00000020, Gen=0 → const_out=0x020, fits=0, ovf_count=1 (saturate build: const_out=0x01F).
- value=0x000007FF, Gen=1 → 0x7FF, fits=1. value=0xFFFFF800 → 0x800, fits=1. value=0x00000800 → const_out=0x800, fits=0 (saturate build: 0x7FF).
- Stream 4 values with out_ready low for cycles 3–5 → in_ready drops once both stages are full, const_out is held stable, and all 4 results emerge in order with none lost or duplicated.
- CNT_W=2: send 5 non-fitting values → ovf_count reads 3 and holds. Then pulse cnt_clr on the same cycle as a 6th overflow → ovf_count=0.
- Assert reset while 2 entries are in flight → next cycle out_valid=0, ovf_count=0, in_ready=1, and no stale result appears afterwards.

Source files
------------

// File: rtl/imm_pack_pkg.sv
// Shared immediate-field constants for imm_pack and imm_gen.
// Field widths, Gen encodings, signed field ranges and the packed result type.
package imm_pack_pkg;

  localparam int IMM_W12 = 12;
  localparam int IMM_W6  = 6;

  localparam logic GEN_12 = 1'b1;
  localparam logic GEN_6  = 1'b0;

  localparam int IMM12_MAX = 2047;
  localparam int IMM12_MIN = -2048;
  localparam int IMM6_MAX  = 31;
  localparam int IMM6_MIN  = -32;

  typedef struct packed {
    logic               fits;
    logic [IMM_W12-1:0] field;
  } pack_res_t;

endpackage

// File: rtl/imm_fit_check.sv
// Combinational fit check and field packing for a 32-bit signed value.
// Build option IMM_PACK_SATURATE_EN clamps non-fitting values instead of truncating.
module imm_fit_check
  import imm_pack_pkg::*;
(
  input  logic [31:0] value_i,
  input  logic        gen_i,
  output pack_res_t   res_o
);

  always_comb begin
    res_o = '0;
    if (gen_i == GEN_12) begin
      // Fits when the bits above the field all match the field's sign bit.
      res_o.fits  = (&value_i[31:11]) | ~(|value_i[31:11]);
      res_o.field = value_i[11:0];
    end else begin
      res_o.fits  = (&value_i[31:5]) | ~(|value_i[31:5]);
      res_o.field = {6'b0, value_i[5:0]};
    end
`ifdef IMM_PACK_SATURATE_EN
    if (!res_o.fits) begin
      if (gen_i == GEN_12) begin
        res_o.field = value_i[31] ? IMM12_MIN[11:0] : IMM12_MAX[11:0];
      end else begin
        res_o.field = {6'b0, (value_i[31] ? IMM6_MIN[5:0] : IMM6_MAX[5:0])};
      end
    end
`else
`endif
  end

endmodule

// File: rtl/imm_pack.sv
// Two-stage valid/ready immediate packer with a saturating overflow counter.
// Optional build macro IMM_PACK_SATURATE_EN selects clamping in imm_fit_check.
module imm_pack
  import imm_pack_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        value,
  input  logic               Gen,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IMM_W12-1:0] const_out,
  output logic               fits,
  output logic [CNT_W-1:0]   ovf_count,
  input  logic               cnt_clr
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // data and valid hold stable while valid is 1 and ready is 0.

  logic               s1_valid_q, s1_valid_d;
  logic [31:0]        s1_value_q, s1_value_d;
  logic               s1_gen_q,   s1_gen_d;
  logic               s2_valid_q, s2_valid_d;
  logic [IMM_W12-1:0] s2_const_q, s2_const_d;
  logic               s2_fits_q,  s2_fits_d;
  logic [CNT_W-1:0]   ovf_q,      ovf_d;
  logic               s1_adv, s2_adv;
  pack_res_t          res;

  imm_fit_check u_fit (
    .value_i (s1_value_q),
    .gen_i   (s1_gen_q),
    .res_o   (res)
  );

  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_value_d = s1_value_q;
    s1_gen_d   = s1_gen_q;
    s2_valid_d = s2_valid_q;
    s2_const_d = s2_const_q;
    s2_fits_d  = s2_fits_q;
    ovf_d      = ovf_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_value_d = value;
        s1_gen_d   = Gen;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_const_d = res.field;
        s2_fits_d  = res.fits;
      end
    end

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    if (cnt_clr) begin
      ovf_d = '0;
    end else if (s2_adv && s1_valid_q && !res.fits && (ovf_q != {CNT_W{1'b1}})) begin
      ovf_d = ovf_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_value_q <= '0;
      s1_gen_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_const_q <= '0;
      s2_fits_q  <= 1'b0;
      ovf_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_value_q <= s1_value_d;
      s1_gen_q   <= s1_gen_d;
      s2_valid_q <= s2_valid_d;
      s2_const_q <= s2_const_d;
      s2_fits_q  <= s2_fits_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign const_out = s2_const_q;
  assign fits      = s2_fits_q;
  assign ovf_count = ovf_q;

endmodule
